// File: rtl/main_mem_responder.sv
// main_mem_responder: whole-line backing memory behind the cache refill /
// write-back port. It takes one line request at a time, waits a fixed
// number of cycles to model main-memory latency, then presents one
// response line until the requester takes it.
//
// Handshake rule, used on both the request and the response side: a
// transfer happens on a rising edge where valid and ready are both high.
// A valid holder keeps its payload stable until that edge. Ready never
// depends combinationally on valid.
module main_mem_responder #(
   parameter int BLOCK_ADDR_WIDTH = 8,
   parameter int WORDS_PER_LINE   = 4,
   parameter int LATENCY          = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic [BLOCK_ADDR_WIDTH-1:0]   req_addr,
   input  logic [32*WORDS_PER_LINE-1:0]  req_wdata,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [32*WORDS_PER_LINE-1:0]  rsp_rdata,
   output logic                          busy,
   output logic [1:0]                    dbg_state
);

   localparam int LINE_W = 32 * WORDS_PER_LINE;
   localparam int DEPTH  = 1 << BLOCK_ADDR_WIDTH;
   // A single-cycle latency still needs a one-bit counter that holds zero.
   localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                       r_state;
   state_t                       w_next;
   logic [CNT_W-1:0]             r_cnt;
   logic                         r_write;
   logic [BLOCK_ADDR_WIDTH-1:0]  r_addr;
   logic [LINE_W-1:0]            r_wdata;
   logic [LINE_W-1:0]            r_rdata;
   logic [LINE_W-1:0]            r_mem [DEPTH];

   logic                         w_accept;
   logic                         w_commit;
   logic                         w_rsp_done;

   // Handshake qualifiers come only from registered state plus the peer's valid/ready.
   assign w_accept   = req_valid && (r_state == S_IDLE);
   assign w_commit   = (r_state == S_WAIT) && (r_cnt == '0);
   assign w_rsp_done = rsp_ready && (r_state == S_RESP);

   assign req_ready  = (r_state == S_IDLE);
   assign rsp_valid  = (r_state == S_RESP);
   assign busy       = (r_state != S_IDLE);
   assign rsp_rdata  = r_rdata;
   assign dbg_state  = r_state;

   // State register; reset forces IDLE, abandoning any uncommitted request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode: accept -> wait out the latency -> hold response.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept)   w_next = S_WAIT;
         S_WAIT: if (w_commit)   w_next = S_RESP;
         S_RESP: if (w_rsp_done) w_next = S_IDLE;
         default:                w_next = S_IDLE;
      endcase
   end

   // Request latch, latency counter and response line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= CNT_W'(LATENCY - 1);
         end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         // A write echoes its own line; a read captures the stored line
         // on the same edge, so back-to-back write/read sees new data.
         if (w_commit) begin
            r_rdata <= r_write ? r_wdata : r_mem[r_addr];
         end
      end
   end

   // Line storage; not reset, so contents persist across reset.
   always_ff @(posedge clk) begin
      if (w_commit && r_write) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

endmodule
